// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding, default sizing and big-endian byte/word packing for the data cache
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, FILL, WRITE} dcache_state_t;
  localparam int XLEN_DEF = 32;
  localparam int LINES_DEF = 8;
  localparam int MEM_LATENCY_DEF = 4;
  typedef logic [0:3][7:0] bytes_t;
  function automatic logic [31:0] to_word(bytes_t b);
    return {b[0], b[1], b[2], b[3]};
  endfunction
  function automatic bytes_t to_bytes(logic [31:0] w);
    return {w[31:24], w[23:16], w[15:8], w[7:0]};
  endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: datapath load/store port and byte-array memory port of the data cache
interface dcache_if import dcache_pkg::*; #(parameter int XLEN = XLEN_DEF);
  logic [XLEN-1:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
  logic cpu_rd, cpu_wr, cpu_stall, mem_write_en;
  bytes_t mem_data_in, mem_data_out;
  modport master(output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_data_out,
                 input cpu_rdata, cpu_stall, mem_addr, mem_data_in, mem_write_en);
  modport slave(input cpu_addr, cpu_wdata, cpu_rd, cpu_wr, mem_data_out,
                output cpu_rdata, cpu_stall, mem_addr, mem_data_in, mem_write_en);
endinterface

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/tag/data arrays with an async read port and one write port; valid clears on reset
module dcache_line_store #(
  parameter int XLEN = 32,
  parameter int LINES = 8,
  parameter int TW = 27
)(
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [$clog2(LINES)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [TW-1:0]            rd_tag,
  output logic [XLEN-1:0]          rd_data,
  input  logic                     we,
  input  logic [$clog2(LINES)-1:0] wr_idx,
  input  logic                     wr_valid,
  input  logic [TW-1:0]            wr_tag,
  input  logic [XLEN-1:0]          wr_data
);
  logic [LINES-1:0] valid;
  logic [TW-1:0]    tags [LINES];
  logic [XLEN-1:0]  data [LINES];
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_data = data[rd_idx];
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) valid <= '0;
    else if (we) valid[wr_idx] <= wr_valid;
  always_ff @(posedge clk)
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate one-word-line data cache.
// Optional DCACHE_STATS_EN adds saturating load hit/miss counters.
module dcache_ctrl import dcache_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int LINES = LINES_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
)(
  input logic clk,
  input logic rst_b,
  dcache_if.slave bus
`ifdef DCACHE_STATS_EN
  , output logic [XLEN-1:0] hit_count
  , output logic [XLEN-1:0] miss_count
`endif
);
  localparam int IW = $clog2(LINES);
  localparam int TW = XLEN - 2 - IW;
  localparam int CW = $clog2(MEM_LATENCY + 1);
  dcache_state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [XLEN-3:0] la;
  logic [XLEN-1:0] ld, rd_data;
  logic [TW-1:0] rd_tag;
  logic rd_valid, hit, idle, done, we, stall, unused;
  assign idle = state == IDLE;
  assign done = cnt == '0;
  assign hit = rd_valid && rd_tag == bus.cpu_addr[XLEN-1 -: TW];
  assign we = idle ? bus.cpu_wr && hit : state == FILL && done;
  assign unused = ^bus.cpu_addr[1:0];
  // Store hits update from the live request; fills complete from the latched miss address
  dcache_line_store #(.XLEN(XLEN), .LINES(LINES), .TW(TW)) u_store (
    .clk     (clk),
    .rst_b   (rst_b),
    .rd_idx  (bus.cpu_addr[2 +: IW]),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .we      (we),
    .wr_idx  (idle ? bus.cpu_addr[2 +: IW] : la[IW-1:0]),
    .wr_valid(1'b1),
    .wr_tag  (idle ? bus.cpu_addr[XLEN-1 -: TW] : la[XLEN-3 -: TW]),
    .wr_data (idle ? bus.cpu_wdata : to_word(bus.mem_data_out))
  );
  always_comb begin
    nxt = state;
    stall = 1'b0;
    bus.cpu_rdata = '0;
    case (state)
      IDLE:
        if (bus.cpu_wr) begin
          nxt = WRITE;
          stall = 1'b1;
        end else if (bus.cpu_rd) begin
          if (hit) bus.cpu_rdata = rd_data;
          else begin
            nxt = FILL;
            stall = 1'b1;
          end
        end
      FILL: begin
        stall = !done;
        if (done) begin
          nxt = IDLE;
          bus.cpu_rdata = to_word(bus.mem_data_out);
        end
      end
      default: begin
        stall = !done;
        if (done) nxt = IDLE;
      end
    endcase
  end
  // Stall drops the moment reset asserts, even with a request still on the bus
  assign bus.cpu_stall = stall && rst_b;
  assign bus.mem_addr = idle ? '0 : {la, 2'b00};
  assign bus.mem_write_en = state == WRITE;
  assign bus.mem_data_in = state == WRITE ? to_bytes(ld) : '0;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      state <= IDLE;
      cnt <= '0;
      la <= '0;
      ld <= '0;
    end else begin
      state <= nxt;
      if (idle && nxt != IDLE) begin
        cnt <= CW'(MEM_LATENCY - 1);
        la <= bus.cpu_addr[XLEN-1:2];
        ld <= bus.cpu_wdata;
      end else if (!done) cnt <= cnt - CW'(1);
    end
`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (idle && !bus.cpu_wr && bus.cpu_rd && hit && !(&hit_count)) hit_count <= hit_count + XLEN'(1);
      if (idle && nxt == FILL && !(&miss_count)) miss_count <= miss_count + XLEN'(1);
    end
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench with a line-level reference cache model and per-cycle output checks
module tb_dcache_ctrl;
  localparam int ML = 4;
  localparam int L = 8;
  logic clk = 0;
  logic rst_b = 0;
  always #5 clk = ~clk;
  dcache_if #(.XLEN(32)) bus();
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif
  dcache_ctrl #(.XLEN(32), .LINES(L), .MEM_LATENCY(ML)) dut (
    .clk  (clk),
    .rst_b(rst_b),
    .bus  (bus)
`ifdef DCACHE_STATS_EN
    , .hit_count (hit_count)
    , .miss_count(miss_count)
`endif
  );
  function automatic logic [0:3][7:0] tb_bytes(logic [31:0] w);
    logic [0:3][7:0] b;
    b[0] = w[31:24];
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    return b;
  endfunction
  function automatic logic [31:0] tb_word(logic [0:3][7:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction
  logic [31:0] mem [0:255];
  always_comb bus.mem_data_out = tb_bytes(mem[bus.mem_addr[9:2]]);
  always @(posedge clk) if (bus.mem_write_en) mem[bus.mem_addr[9:2]] <= tb_word(bus.mem_data_in);
  bit ref_valid [L];
  logic [29:0] ref_line [L];
  logic [31:0] ref_data [L];
  int mh, mm;
  int tests = 0, fails = 0;
  bit act = 0, chk_en = 0;
  int kind, cyc, tlast, nstall, nwe;
  logic [31:0] t_addr, t_data, last_rd;
  logic [0:3][7:0] last_din;
  logic [31:0] es, ew, ea, er, ed;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask
  // kind: 0 load hit, 1 load miss, 2 store
  always @(negedge clk) if (chk_en) begin
    {es, ew, ea, er, ed} = '0;
    if (act) begin
      if (kind == 0) er = t_data;
      else begin
        es = 32'(cyc < ML);
        ea = cyc >= 1 ? {t_addr[31:2], 2'b00} : 32'h0;
        if (kind == 1) er = cyc == ML ? t_data : 32'h0;
        else begin
          ew = 32'(cyc >= 1);
          ed = cyc >= 1 ? t_data : 32'h0;
        end
      end
    end
    chk("cpu_stall", 32'(bus.cpu_stall), es);
    chk("mem_write_en", 32'(bus.mem_write_en), ew);
    chk("mem_addr", bus.mem_addr, ea);
    chk("cpu_rdata", bus.cpu_rdata, er);
    chk("mem_data_in", tb_word(bus.mem_data_in), ed);
    if (act && bus.cpu_stall) nstall++;
    if (act && bus.mem_write_en) begin
      nwe++;
      last_din = bus.mem_data_in;
    end
    if (act && cyc == tlast) last_rd = bus.cpu_rdata;
  end
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int idx;
    bit h;
    idx = int'(a[31:2]) % L;
    h = ref_valid[idx] && ref_line[idx] == a[31:2];
    kind = wr ? 2 : (h ? 0 : 1);
    tlast = kind == 0 ? 0 : ML;
    t_addr = a;
    t_data = wr ? d : (h ? ref_data[idx] : mem[a[9:2]]);
    nstall = 0;
    nwe = 0;
    bus.cpu_addr = a;
    bus.cpu_wdata = d;
    bus.cpu_rd = !wr;
    bus.cpu_wr = wr;
    act = 1;
    for (int c = 0; c <= tlast; c++) begin
      cyc = c;
      @(posedge clk);
      #1;
    end
    act = 0;
    bus.cpu_rd = 0;
    bus.cpu_wr = 0;
    if (kind == 1) begin
      ref_valid[idx] = 1;
      ref_line[idx] = a[31:2];
      ref_data[idx] = t_data;
      mm++;
    end else if (kind == 0) mh++;
    else begin
      if (h) ref_data[idx] = d;
      chk("mem_after_store", mem[a[9:2]], d);
    end
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, 32'(mh));
    chk("miss_count", miss_count, 32'(mm));
`endif
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i), 8'hA5, 8'(i), 8'h5A};
    mem[4] = 32'hDEADBEEF;
    mem[12] = 32'h0BADF00D;
    for (int i = 0; i < L; i++) ref_valid[i] = 0;
    mh = 0;
    mm = 0;
    bus.cpu_addr = 0;
    bus.cpu_wdata = 0;
    bus.cpu_rd = 0;
    bus.cpu_wr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    chk("rst_we", 32'(bus.mem_write_en), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_din", tb_word(bus.mem_data_in), 0);
    rst_b = 1;
    chk_en = 1;
    @(posedge clk);
    #1;
    access(0, 32'h10, 0);
    chk("cold_stalls", nstall, 4);
    chk("cold_rdata", last_rd, 32'hDEADBEEF);
    access(0, 32'h10, 0);
    chk("rehit_stalls", nstall, 0);
    chk("rehit_rdata", last_rd, 32'hDEADBEEF);
    access(0, 32'h30, 0);
    chk("conflict_stalls", nstall, 4);
    chk("conflict_rdata", last_rd, 32'h0BADF00D);
    access(0, 32'h10, 0);
    chk("reload_stalls", nstall, 4);
    access(1, 32'h10, 32'h12345678);
    chk("sthit_stalls", nstall, 4);
    chk("sthit_we_cycles", nwe, 4);
    chk("sthit_byte0", 32'(last_din[0]), 32'h12);
    chk("sthit_byte3", 32'(last_din[3]), 32'h78);
    access(0, 32'h10, 0);
    chk("after_store_stalls", nstall, 0);
    chk("after_store_rdata", last_rd, 32'h12345678);
    access(1, 32'h44, 32'hCAFEF00D);
    chk("stmiss_mem", mem[17], 32'hCAFEF00D);
    access(0, 32'h44, 0);
    chk("noalloc_stalls", nstall, 4);
    chk("noalloc_rdata", last_rd, 32'hCAFEF00D);
    access(0, 32'h30, 0);
    chk_en = 0;
    bus.cpu_addr = 32'h10;
    bus.cpu_rd = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_b = 0;
    #1;
    chk("midfill_stall", 32'(bus.cpu_stall), 0);
    chk("midfill_we", 32'(bus.mem_write_en), 0);
    chk("midfill_addr", bus.mem_addr, 0);
    bus.cpu_rd = 0;
    @(posedge clk);
    #1;
    rst_b = 1;
    for (int i = 0; i < L; i++) ref_valid[i] = 0;
    mh = 0;
    mm = 0;
    chk_en = 1;
    access(0, 32'h10, 0);
    chk("post_reset_stalls", nstall, 4);
    chk("post_reset_rdata", last_rd, 32'h12345678);
    access(0, 32'h10, 0);
    access(0, 32'h10, 0);
    access(1, 32'h10, 32'h55AA55AA);
`ifdef DCACHE_STATS_EN
    chk("stats_hits", hit_count, 2);
    chk("stats_misses", miss_count, 1);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
